// File: rtl/cgra4ml_mem_pkg.sv
// rtl/cgra4ml_mem_pkg.sv - requester/state enums and beat-address LSB helper for mem_port_arbiter
`ifndef AXI_WIDTH
`define AXI_WIDTH 128
`endif

package cgra4ml_mem_pkg;

    typedef enum logic [1:0] {
        REQ_PX  = 2'd0,
        REQ_WT  = 2'd1,
        REQ_OUT = 2'd2
    } req_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Byte-offset bits dropped from a 32-bit byte address to form a beat address.
    function automatic int beat_lsb(input int axi_width);
        return $clog2(axi_width) - 3;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// rtl/mem_port_arbiter_rr.sv - rr_arbiter3: combinational round-robin pick over px/wt/out
module rr_arbiter3
    import cgra4ml_mem_pkg::*;
(
    input  logic [2:0] req_i,
    input  req_e       last_i,
    output logic       gnt_valid_o,
    output req_e       gnt_o
);

    // Search order starts at the requester after last_i and wraps px->wt->out.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_o       = REQ_PX;
        case (last_i)
            REQ_PX: begin
                if (req_i[1])      gnt_o = REQ_WT;
                else if (req_i[2]) gnt_o = REQ_OUT;
                else               gnt_o = REQ_PX;
            end
            REQ_WT: begin
                if (req_i[2])      gnt_o = REQ_OUT;
                else if (req_i[0]) gnt_o = REQ_PX;
                else               gnt_o = REQ_WT;
            end
            default: begin
                if (req_i[0])      gnt_o = REQ_PX;
                else if (req_i[1]) gnt_o = REQ_WT;
                else               gnt_o = REQ_OUT;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - px/wt read and out write arbiter onto one RAM port; optional ARB_OUT_PRIORITY_EN
`ifndef AXI_WIDTH
`define AXI_WIDTH 128
`endif

module mem_port_arbiter
    import cgra4ml_mem_pkg::*;
#(
    parameter int AXI_WIDTH  = `AXI_WIDTH,
    parameter int ADDR_WIDTH = 32 - beat_lsb(AXI_WIDTH),
    parameter int MAX_BURST  = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     px_req_valid,
    output logic                     px_req_ready,
    input  logic [ADDR_WIDTH-1:0]    px_req_addr,
    output logic                     px_rvalid,
    output logic [AXI_WIDTH-1:0]     px_rdata,

    input  logic                     wt_req_valid,
    output logic                     wt_req_ready,
    input  logic [ADDR_WIDTH-1:0]    wt_req_addr,
    output logic                     wt_rvalid,
    output logic [AXI_WIDTH-1:0]     wt_rdata,

    input  logic                     out_req_valid,
    output logic                     out_req_ready,
    input  logic [ADDR_WIDTH-1:0]    out_req_addr,
    input  logic [AXI_WIDTH-1:0]     out_req_wdata,
    input  logic [AXI_WIDTH/8-1:0]   out_req_wstrb,

    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [AXI_WIDTH-1:0]     mem_wdata,
    output logic [AXI_WIDTH/8-1:0]   mem_wstrb,
    input  logic [AXI_WIDTH-1:0]     mem_rdata
);

    localparam int STRB_W = AXI_WIDTH / 8;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_e        state_q, state_d;
    req_e              owner_q, owner_d;
    req_e              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              owner_valid;
    logic              rearb;
    logic              rr_valid;
    logic              gnt_valid;
    req_e              rr_gnt;
    req_e              pick;
    req_e              gnt;

    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [AXI_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]     mem_wstrb_q, mem_wstrb_d;

    logic                  tag1_vld_q, tag1_vld_d;
    logic                  tag1_wt_q, tag1_wt_d;
    logic                  tag2_vld_q, tag2_wt_q;
    logic                  px_rvalid_q, wt_rvalid_q;
    logic [AXI_WIDTH-1:0]  px_rdata_q, wt_rdata_q;

    rr_arbiter3 u_rr (
        .req_i       ({out_req_valid, wt_req_valid, px_req_valid}),
        .last_i      (last_q),
        .gnt_valid_o (rr_valid),
        .gnt_o       (rr_gnt)
    );

`ifdef ARB_OUT_PRIORITY_EN
    assign pick = out_req_valid ? REQ_OUT : rr_gnt;
`else
    assign pick = rr_gnt;
`endif

    always_comb begin
        case (owner_q)
            REQ_PX:  owner_valid = px_req_valid;
            REQ_WT:  owner_valid = wt_req_valid;
            default: owner_valid = out_req_valid;
        endcase
    end

    // An owner that drops valid releases the lock and a new pick happens in the same cycle.
    assign rearb     = (state_q == ST_IDLE) || !owner_valid;
    assign gnt_valid = !rst && (rearb ? rr_valid : 1'b1);
    assign gnt       = rearb ? pick : owner_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= REQ_PX;
            last_q  <= REQ_OUT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (rearb) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
        if (gnt_valid) begin
            owner_d = gnt;
            last_d  = gnt;
            if (rearb) begin
                if (MAX_BURST > 1) begin
                    state_d = ST_LOCK;
                    cnt_d   = CNT_ONE;
                end
            end else if (cnt_q + CNT_ONE == CNT_MAX) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        px_req_ready  = gnt_valid && (gnt == REQ_PX);
        wt_req_ready  = gnt_valid && (gnt == REQ_WT);
        out_req_ready = gnt_valid && (gnt == REQ_OUT);
        mem_en_d      = gnt_valid;
        mem_we_d      = gnt_valid && (gnt == REQ_OUT);
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        mem_wstrb_d   = '0;
        tag1_vld_d    = gnt_valid && (gnt != REQ_OUT);
        tag1_wt_d     = (gnt == REQ_WT);
        if (gnt_valid) begin
            case (gnt)
                REQ_PX:  mem_addr_d = px_req_addr;
                REQ_WT:  mem_addr_d = wt_req_addr;
                default: begin
                    mem_addr_d  = out_req_addr;
                    mem_wdata_d = out_req_wdata;
                    mem_wstrb_d = out_req_wstrb;
                end
            endcase
        end
    end

    // Read tag follows the command (stage 1) and the RAM data cycle (stage 2).
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            tag1_vld_q  <= 1'b0;
            tag1_wt_q   <= 1'b0;
            tag2_vld_q  <= 1'b0;
            tag2_wt_q   <= 1'b0;
            px_rvalid_q <= 1'b0;
            wt_rvalid_q <= 1'b0;
            px_rdata_q  <= '0;
            wt_rdata_q  <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            tag1_vld_q  <= tag1_vld_d;
            tag1_wt_q   <= tag1_wt_d;
            tag2_vld_q  <= tag1_vld_q;
            tag2_wt_q   <= tag1_wt_q;
            px_rvalid_q <= tag2_vld_q && !tag2_wt_q;
            wt_rvalid_q <= tag2_vld_q && tag2_wt_q;
            if (tag2_vld_q && !tag2_wt_q) px_rdata_q <= mem_rdata;
            if (tag2_vld_q && tag2_wt_q)  wt_rdata_q <= mem_rdata;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign px_rvalid = px_rvalid_q;
    assign wt_rvalid = wt_rvalid_q;
    assign px_rdata  = px_rdata_q;
    assign wt_rdata  = wt_rdata_q;

endmodule
